// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// default widths and the halt-opcode decode helper.
package fetch_pkg;

  localparam int          ADDR_W_DEF   = 8;
  localparam int          DATA_W_DEF   = 32;
  localparam int          CNT_W_DEF    = 16;
  localparam logic [5:0]  HALT_OPC_DEF = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // True when the opcode field of a fetched word marks a halt instruction.
  function automatic logic is_halt(input logic [5:0] opc, input logic [5:0] halt_opc);
    return (opc == halt_opc);
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output stage between fetch and decode.
// Flush has priority over load; with neither, a completed handshake
// empties the stage, otherwise contents hold.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;

  // Stage register: flush empties, load captures, handshake drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational
// instruction memory, feeds decode through a one-entry output stage and
// stops on a halt opcode until the next start pulse.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]        HALT_OPC = HALT_OPC_DEF,
  parameter int                CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              busy_q;
  logic              halted_q;
  logic [CNT_W-1:0]  retired_q;

  logic              ld_ok;
  logic              fire;
  logic              restart;
  logic              halt_word;
  logic              out_load;
  logic              out_flush;

  assign imem_addr = pc_q;
  assign ld_ok     = !inst_valid || inst_ready;
  assign fire      = inst_valid && inst_ready;
  // start only matters outside RUN; inside RUN it is ignored.
  assign restart   = start && (state_q != ST_RUN);
  assign halt_word = is_halt(imem_data[DATA_W-1 -: 6], HALT_OPC);

  // A redirect flushes the stage and blocks capture; a restart empties it.
  assign out_flush = ((state_q == ST_RUN) && br_valid) || restart;
  assign out_load  = (state_q == ST_RUN) && !br_valid && ld_ok;

  fetch_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (out_load),
    .flush_i (out_flush),
    .data_i  (imem_data),
    .pc_i    (pc_q),
    .ready_i (inst_ready),
    .data_o  (inst_out),
    .pc_o    (inst_pc),
    .valid_o (inst_valid)
  );

  // Fetch FSM with PC update and registered busy/halted flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (br_valid) begin
            // Redirect beats a coincident halt word: word dropped, stay in RUN.
            pc_q <= br_target;
          end else if (ld_ok) begin
            if (halt_word) begin
              state_q  <= ST_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating retired-instruction counter; a restart clear beats a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (restart) begin
      retired_q <= '0;
    end else if (fire && (retired_q != {CNT_W{1'b1}})) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign busy    = busy_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule
